// File: rtl/reg_swap_arbiter_pkg.sv
// rtl/reg_swap_arbiter_pkg.sv - shared types and helpers for the swap-register arbiter
package reg_swap_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // Requester index width; a single requester still gets a 1-bit id.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// rtl/rr_arbiter_onehot.sv - combinational round-robin pick starting at ptr
module rr_arbiter_onehot
  import reg_swap_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [2*NREQ-1:0] doubled;
  logic [NREQ-1:0]   rotated;
  int                first;
  int                pos;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    doubled = {req, req} >> ptr;
    rotated = doubled[NREQ-1:0];
    first   = 0;
    any     = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        first = k;
        any   = 1'b1;
      end
    end
    pos = first + int'(ptr);
    if (pos >= NREQ) pos = pos - NREQ;
    idx   = IDW'(pos);
    grant = any ? (NREQ'(1) << pos) : '0;
  end

endmodule

// File: rtl/reg_swap_arbiter.sv
// rtl/reg_swap_arbiter.sv - round-robin shared register with atomic swap and tagged responses
module reg_swap_arbiter
  import reg_swap_arbiter_pkg::*;
#(
  parameter int               NREQ      = 4,
  parameter int               NBITS     = 32,
  parameter logic [NBITS-1:0] RESET_VAL = '0,
  localparam int              IDW       = idw(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_val,
  output logic [NREQ-1:0]       req_rdy,
  input  logic [NREQ-1:0]       req_wen,
  input  logic [NREQ*NBITS-1:0] req_data,
  output logic                  resp_val,
  input  logic                  resp_rdy,
  output logic [IDW-1:0]        resp_id,
  output logic [NBITS-1:0]      resp_data,
  output logic [NBITS-1:0]      q
);

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr, ptr_nxt;
  logic [IDW-1:0]   gnt_idx;
  logic [NREQ-1:0]  grant;
  logic             gnt_any;
  logic             can_accept;
  logic             req_fire;
  logic             resp_fire;
  logic             wr_en;
  logic [NBITS-1:0] wr_data;

  rr_arbiter_onehot #(.NREQ(NREQ)) u_arb (
    .req   (req_val),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // A pending response may be replaced in the same cycle it is consumed.
  always_comb begin
    resp_val   = (state == RESP);
    can_accept = (state == IDLE) | resp_rdy;
    req_rdy    = grant & {NREQ{can_accept & ~reset}};
    req_fire   = gnt_any & can_accept & ~reset;
    resp_fire  = resp_val & resp_rdy;
    wr_en      = req_wen[gnt_idx];
    wr_data    = req_data[int'(gnt_idx)*NBITS +: NBITS];

    state_nxt = state;
    case (state)
      IDLE:    if (req_fire) state_nxt = RESP;
      RESP:    if (resp_fire && !req_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    ptr_nxt = ptr;
    if (req_fire) ptr_nxt = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      q         <= RESET_VAL;
      resp_id   <= '0;
      resp_data <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if (req_fire) begin
        resp_data <= q;
        resp_id   <= gnt_idx;
        if (wr_en) q <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_swap_arbiter.sv
// tb/tb_reg_swap_arbiter.sv - directed and random checks of reg_swap_arbiter against a behavioural model
module tb_reg_swap_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_val;
  logic [3:0]   req_rdy;
  logic [3:0]   req_wen;
  logic [127:0] req_data;
  logic         resp_val;
  logic         resp_rdy;
  logic [1:0]   resp_id;
  logic [31:0]  resp_data;
  logic [31:0]  q;

  int checks = 0;
  int errors = 0;

  reg_swap_arbiter #(.NREQ(4), .NBITS(32), .RESET_VAL(32'd0)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_wen   (req_wen),
    .req_data  (req_data),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_id   (resp_id),
    .resp_data (resp_data),
    .q         (q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: register value, pending response, rotating priority start.
  logic [31:0] mq, mdata;
  int          mid, mptr;
  bit          mpend, started;

  always @(negedge clk) begin : cmp
    int g, idx;
    bit can;
    logic [3:0] exp_rdy;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      idx = (mptr + k) % 4;
      if (g < 0 && req_val[idx]) g = idx;
    end
    can = !mpend || resp_rdy;
    exp_rdy = (reset || g < 0 || !can) ? 4'b0000 : (4'b0001 << g);
    if (started) begin
      chk("m_req_rdy", req_rdy, exp_rdy);
      chk("m_resp_val", resp_val, mpend);
      chk("m_resp_id", resp_id, mid[1:0]);
      chk("m_resp_data", resp_data, mdata);
      chk("m_q", q, mq);
    end
    if (reset) begin
      mq = 0; mdata = 0; mid = 0; mptr = 0; mpend = 0; started = 1;
    end else if (g >= 0 && can) begin
      mdata = mq;
      mid   = g;
      if (req_wen[g]) mq = req_data[g*32 +: 32];
      mpend = 1;
      mptr  = (g + 1) % 4;
    end else if (mpend && resp_rdy) begin
      mpend = 0;
    end
  end

  int fair_rd[5] = '{0, 10, 11, 12, 13};

  initial begin
    reset = 1'b1; req_val = 4'hF; req_wen = 4'h0; req_data = '0; resp_rdy = 1'b0;
    tick(); tick();
    chk("rst_req_rdy", req_rdy, 4'b0000);
    chk("rst_q", q, 0);
    chk("rst_resp_val", resp_val, 0);

    reset = 1'b0; req_val = 4'b0001; req_wen = 4'b0001; req_data[31:0] = 32'h5;
    #1 chk("wr_req_rdy", req_rdy, 4'b0001);
    tick();
    chk("wr_resp_val", resp_val, 1);
    chk("wr_resp_id", resp_id, 0);
    chk("wr_resp_data", resp_data, 0);
    chk("wr_q", q, 5);
    req_val = 4'b0000; resp_rdy = 1'b1;
    tick();

    reset = 1'b1;
    tick();
    reset = 1'b0; req_val = 4'hF; req_wen = 4'hF; resp_rdy = 1'b1;
    req_data = {32'd13, 32'd12, 32'd11, 32'd10};
    for (int k = 0; k < 5; k++) begin
      #1 chk("fair_req_rdy", req_rdy, 4'b0001 << (k % 4));
      tick();
      chk("fair_resp_id", resp_id, k % 4);
      chk("fair_resp_data", resp_data, fair_rd[k]);
    end

    resp_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_req_rdy", req_rdy, 4'b0000);
      chk("bp_resp_val", resp_val, 1);
      chk("bp_resp_id", resp_id, 0);
      chk("bp_resp_data", resp_data, 13);
      chk("bp_q", q, 10);
      tick();
    end
    resp_rdy = 1'b1;
    #1 chk("bp_release_rdy", req_rdy, 4'b0010);
    tick();
    chk("bp_next_id", resp_id, 1);
    chk("bp_next_data", resp_data, 10);
    chk("bp_next_q", q, 11);
    req_val = 4'b0000;
    tick();

    req_val = 4'b0100; req_wen = 4'b0100; req_data[95:64] = 32'd7;
    tick();
    chk("ro_setup_q", q, 7);
    chk("ro_setup_data", resp_data, 11);
    req_wen = 4'b0000; req_data[95:64] = 32'h99;
    #1 chk("ro_req_rdy", req_rdy, 4'b0100);
    tick();
    chk("ro_resp_data", resp_data, 7);
    chk("ro_resp_id", resp_id, 2);
    chk("ro_q", q, 7);

    req_val = 4'hF; resp_rdy = 1'b0;
    #1 chk("mid_resp_val", resp_val, 1);
    reset = 1'b1;
    #1 chk("mid_req_rdy", req_rdy, 4'b0000);
    tick();
    chk("mid_resp_val_clr", resp_val, 0);
    chk("mid_q", q, 0);
    reset = 1'b0; resp_rdy = 1'b1;
    #1 chk("mid_ptr0", req_rdy, 4'b0001);

    for (int n = 0; n < 300; n++) begin
      tick();
      reset    = ($urandom_range(0, 31) == 0);
      req_val  = 4'($urandom);
      req_wen  = 4'($urandom);
      req_data = {$urandom, $urandom, $urandom, $urandom};
      resp_rdy = ($urandom_range(0, 3) != 0);
    end
    tick();
    reset = 1'b0; req_val = 4'h0; resp_rdy = 1'b1;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
